// File: rtl/vsa_ifetch_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : vsa_ifetch_cache_if
//  Description : Bundles the core-facing fetch signals and the instruction-
//                memory req/ack signals of the VSA fetch front end.
//                master = fetch cache, slave = core plus instruction memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface vsa_ifetch_cache_if #(
    parameter int AW = 5,
    parameter int IW = 12,
    parameter int CW = 8
);
    // Core side
    logic [AW-1:0] pc;
    logic [IW-1:0] instruction;
    logic          ready;
    logic          flush;
    logic          fetch_strobe;
    logic          fetch_late;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    // Instruction-memory side
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_ack;

    modport master (
        input  pc,
        input  flush,
        input  fetch_strobe,
        input  imem_rdata,
        input  imem_ack,
        output instruction,
        output ready,
        output fetch_late,
        output hit_count,
        output miss_count,
        output imem_req,
        output imem_addr
    );

    modport slave (
        output pc,
        output flush,
        output fetch_strobe,
        output imem_rdata,
        output imem_ack,
        input  instruction,
        input  ready,
        input  fetch_late,
        input  hit_count,
        input  miss_count,
        input  imem_req,
        input  imem_addr
    );
endinterface
`default_nettype wire

// File: rtl/vsa_ifetch_cache.sv
`default_nettype none
// ============================================================================
//  Module      : vsa_ifetch_cache
//  Description : Instruction-fetch front end for the VSA core. A direct-mapped
//                cache of even-PC instructions sits in front of a slow
//                variable-latency req/ack instruction memory. Keeps saturating
//                hit/miss counters and a sticky late-fetch flag.
//  Revision    : 1.0  initial release
// ============================================================================
module vsa_ifetch_cache #(
    parameter int AW         = 5,
    parameter int IW         = 12,
    parameter int INDEX_BITS = 2,
    parameter int CW         = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    vsa_ifetch_cache_if.master  bus
);

    localparam int            LINES   = 1 << INDEX_BITS;
    localparam int            TW      = AW - INDEX_BITS - 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                state;
    logic [AW-1:0]         pc_q;
    logic [IW-1:0]         instruction_q;
    logic                  ready_q;
    logic                  req_q;
    logic [AW-1:0]         addr_q;
    logic [CW-1:0]         hit_q;
    logic [CW-1:0]         miss_q;
    logic                  late_q;

    logic [LINES-1:0]      valid;
    logic [TW-1:0]         tag_mem  [LINES];
    logic [IW-1:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [TW-1:0]         lookup_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TW-1:0]         fill_tag;
    logic                  lookup_hit;
    logic                  lookup_en;
    logic                  fill_we;

    // Lookups always use the live pc; fills target the pc captured at the miss.
    assign lookup_idx = bus.pc[INDEX_BITS:1];
    assign lookup_tag = bus.pc[AW-1:INDEX_BITS+1];
    assign fill_idx   = pc_q[INDEX_BITS:1];
    assign fill_tag   = pc_q[AW-1:INDEX_BITS+1];
    assign lookup_hit = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);

    // A lookup is needed whenever the pc moved or the current word is not yet
    // valid; flush suppresses it so a same-cycle hit is never counted.
    assign lookup_en  = (state == ST_IDLE) && ((bus.pc != pc_q) || !ready_q) && !bus.flush;

    // A fill lands unless a flush arrives in the very cycle of the ack.
    assign fill_we    = (state == ST_WAIT) && bus.imem_ack && !bus.flush;

    // Line payload and tag storage; no reset needed since valid gates every hit.
    always_ff @(posedge clock) begin
        if (fill_we) begin
            data_mem[fill_idx] <= bus.imem_rdata;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    // Valid bits: flush clears them all and takes priority over a fill.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (bus.flush) begin
            valid <= '0;
        end else if (fill_we) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Lookup / fill sequencer; every core- and memory-facing output is registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pc_q          <= '0;
            instruction_q <= '0;
            ready_q       <= 1'b0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            hit_q         <= '0;
            miss_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.flush) begin
                        ready_q <= 1'b0;
                    end else if (lookup_en) begin
                        pc_q <= bus.pc;
                        if (lookup_hit) begin
                            instruction_q <= data_mem[lookup_idx];
                            ready_q       <= 1'b1;
                            if (hit_q != CNT_MAX) begin
                                hit_q <= hit_q + CW'(1);
                            end
                        end else begin
                            ready_q <= 1'b0;
                            req_q   <= 1'b1;
                            addr_q  <= {bus.pc[AW-1:1], 1'b0};
                            if (miss_q != CNT_MAX) begin
                                miss_q <= miss_q + CW'(1);
                            end
                            state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // The request is never abandoned on a pc change; it runs to ack.
                    ready_q <= 1'b0;
                    if (bus.imem_ack) begin
                        req_q <= 1'b0;
                        state <= ST_IDLE;
                        // Forward the returning word only if the core still wants it
                        // and no flush is discarding it in the same cycle.
                        if (!bus.flush && (bus.pc == pc_q)) begin
                            instruction_q <= bus.imem_rdata;
                            ready_q       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky record of the core sampling an instruction that was not ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            late_q <= 1'b0;
        end else if (bus.fetch_strobe && !ready_q) begin
            late_q <= 1'b1;
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.ready       = ready_q;
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.hit_count   = hit_q;
    assign bus.miss_count  = miss_q;
    assign bus.fetch_late  = late_q;

endmodule
`default_nettype wire

// File: tb/tb_vsa_ifetch_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vsa_ifetch_cache
//  Description : Self-checking bench for vsa_ifetch_cache. A latency-
//                programmable memory responder serves requests; a reference
//                model tracks which address each cache index holds and the
//                expected statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vsa_ifetch_cache;

    logic clock = 1'b0;
    logic reset_n;

    vsa_ifetch_cache_if #(.AW(5), .IW(12), .CW(8)) bus ();

    vsa_ifetch_cache #(
        .AW(5), .IW(12), .INDEX_BITS(2), .CW(8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Reference state
    logic [11:0] mem [32];
    int          cached [4];      // address held by each index, -1 if invalid
    int          exp_hit;
    int          exp_miss;
    int          m_pc;
    bit          m_ready;

    int          compared;
    int          mismatched;

    // Responder state
    int          cur_lat;
    bit          busy;
    int          wait_left;
    int          req_cycles;
    int          last_req_cycles;
    logic [4:0]  req_addr;
    int          addr_unstable;

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) cached[i] = -1;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (bus.ready !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("ready_timeout", {31'd0, bus.ready}, 32'd1);
    endtask

    // Move the core pc to a; called and returns at a negedge.
    task automatic goto_pc(input logic [4:0] a, input int lat);
        bit lookup;
        bit hit;
        int ix;
        int k;
        ix     = int'(a[2:1]);
        lookup = (int'(a) != m_pc) || !m_ready;
        hit    = lookup && (cached[ix] == int'(a));
        cur_lat = lat;
        bus.pc  = a;
        @(negedge clock);
        if (!lookup) begin
            check("hold_ready", {31'd0, bus.ready}, 32'd1);
            check("hold_instr", 32'(bus.instruction), 32'(mem[a]));
            check("hold_hits", 32'(bus.hit_count), exp_hit);
            return;
        end
        m_pc = int'(a);
        if (hit) begin
            exp_hit = sat(exp_hit);
            check("hit_ready", {31'd0, bus.ready}, 32'd1);
            check("hit_instr", 32'(bus.instruction), 32'(mem[a]));
            check("hit_count", 32'(bus.hit_count), exp_hit);
            check("hit_miss_count", 32'(bus.miss_count), exp_miss);
        end else begin
            exp_miss = sat(exp_miss);
            check("miss_req", {31'd0, bus.imem_req}, 32'd1);
            check("miss_addr", 32'(bus.imem_addr), 32'(a));
            check("miss_ready", {31'd0, bus.ready}, 32'd0);
            check("miss_count", 32'(bus.miss_count), exp_miss);
            wait_ready(k);
            check("miss_latency", k, lat);
            check("miss_instr", 32'(bus.instruction), 32'(mem[a]));
            check("miss_req_drop", {31'd0, bus.imem_req}, 32'd0);
            cached[ix] = int'(a);
        end
        m_ready = 1'b1;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        check("flush_ready", {31'd0, bus.ready}, 32'd0);
        clear_model();
        m_ready = 1'b0;
    endtask

    // Instruction memory: ack after cur_lat cycles of request, address latched.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        busy = 1'b0;
        addr_unstable = 0;
        forever begin
            @(negedge clock);
            bus.imem_ack = 1'b0;
            if (bus.imem_req === 1'b1) begin
                if (!busy) begin
                    busy       = 1'b1;
                    wait_left  = cur_lat - 1;
                    req_cycles = 0;
                    req_addr   = bus.imem_addr;
                end else begin
                    wait_left--;
                    if (bus.imem_addr !== req_addr) addr_unstable++;
                end
                req_cycles++;
                if (wait_left <= 0) begin
                    bus.imem_ack    = 1'b1;
                    bus.imem_rdata  = mem[req_addr];
                    busy            = 1'b0;
                    last_req_cycles = req_cycles;
                end
            end
        end
    end

    initial begin
        int k;
        logic [4:0] a;
        compared   = 0;
        mismatched = 0;
        exp_hit    = 0;
        exp_miss   = 0;
        m_pc       = 0;
        m_ready    = 1'b0;
        cur_lat    = 1;
        clear_model();
        for (int i = 0; i < 32; i++) mem[i] = 12'((i << 7) | $urandom_range(0, 127));
        mem[0] = 12'h9A3;
        if (mem[19] == 12'h9A3) mem[19] = 12'h9A2;

        reset_n          = 1'b0;
        bus.pc           = '0;
        bus.flush        = 1'b0;
        bus.fetch_strobe = 1'b0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_instr", 32'(bus.instruction), 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_late", {31'd0, bus.fetch_late}, 32'd0);
        check("rst_hits", 32'(bus.hit_count), 32'd0);
        check("rst_miss", 32'(bus.miss_count), 32'd0);
        reset_n = 1'b1;

        // T1: cold miss at pc 0, ack after 3 cycles
        goto_pc(5'd0, 3);
        check("t1_req_cycles", last_req_cycles, 32'd3);
        check("t1_instr", 32'(bus.instruction), 32'h9A3);
        check("t1_miss_count", 32'(bus.miss_count), 32'd1);

        // Strobe while ready must not set the late flag
        bus.fetch_strobe = 1'b1;
        @(negedge clock);
        bus.fetch_strobe = 1'b0;
        check("late_when_ready", {31'd0, bus.fetch_late}, 32'd0);

        // T2: 0 -> 2 -> 0
        goto_pc(5'd2, 1);
        goto_pc(5'd0, 1);
        check("t2_hits", 32'(bus.hit_count), 32'd1);
        check("t2_miss", 32'(bus.miss_count), 32'd2);

        // T3: conflict on index 0
        goto_pc(5'd8, 2);
        goto_pc(5'd0, 2);
        check("t3_miss", 32'(bus.miss_count), 32'd4);

        // T4: pc moves from 4 to 6 while 4 is outstanding
        do_flush();
        cur_lat = 3;
        bus.pc  = 5'd4;
        @(negedge clock);
        exp_miss = sat(exp_miss);
        check("t4_req4", {31'd0, bus.imem_req}, 32'd1);
        check("t4_addr4", 32'(bus.imem_addr), 32'd4);
        bus.pc = 5'd6;
        k = 0;
        while (bus.imem_req === 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
            if (bus.imem_req === 1'b1) check("t4_addr_hold", 32'(bus.imem_addr), 32'd4);
        end
        check("t4_ready_after_stale", {31'd0, bus.ready}, 32'd0);
        cached[2] = 4;
        @(negedge clock);
        exp_miss = sat(exp_miss);
        check("t4_req6", {31'd0, bus.imem_req}, 32'd1);
        check("t4_addr6", 32'(bus.imem_addr), 32'd6);
        check("t4_ready6", {31'd0, bus.ready}, 32'd0);
        wait_ready(k);
        check("t4_instr6", 32'(bus.instruction), 32'(mem[6]));
        check("t4_miss", 32'(bus.miss_count), exp_miss);
        cached[3] = 6;
        m_pc = 6;
        m_ready = 1'b1;
        goto_pc(5'd4, 1);   // stale fill was kept: hit

        // T5: flush coinciding with a hit lookup of 6
        bus.pc    = 5'd6;
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        check("t5_ready", {31'd0, bus.ready}, 32'd0);
        check("t5_hits", 32'(bus.hit_count), exp_hit);
        clear_model();
        cur_lat = 2;
        @(negedge clock);
        exp_miss = sat(exp_miss);
        check("t5_req", {31'd0, bus.imem_req}, 32'd1);
        check("t5_addr", 32'(bus.imem_addr), 32'd6);
        wait_ready(k);
        check("t5_instr", 32'(bus.instruction), 32'(mem[6]));
        cached[3] = 6;
        m_pc = 6;
        m_ready = 1'b1;

        // Flush coinciding with ack: line stays invalid, pc 0 misses again
        cur_lat = 3;
        bus.pc  = 5'd0;
        @(negedge clock);
        exp_miss = sat(exp_miss);
        check("fa_req", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        bus.flush = 1'b1;     // responder raises ack at this same negedge
        @(negedge clock);
        bus.flush = 1'b0;
        check("fa_ready", {31'd0, bus.ready}, 32'd0);
        check("fa_req_drop", {31'd0, bus.imem_req}, 32'd0);
        clear_model();
        cur_lat = 1;
        @(negedge clock);
        exp_miss = sat(exp_miss);
        check("fa_rereq", {31'd0, bus.imem_req}, 32'd1);
        wait_ready(k);
        check("fa_instr", 32'(bus.instruction), 32'(mem[0]));
        check("fa_miss", 32'(bus.miss_count), exp_miss);
        cached[0] = 0;
        m_pc = 0;
        m_ready = 1'b1;

        // Randomized pc walk with random latencies and occasional flushes
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_flush();
            end else begin
                a = 5'($urandom_range(0, 15) * 2);
                goto_pc(a, int'($urandom_range(1, 4)));
            end
        end
        check("rand_hits", 32'(bus.hit_count), exp_hit);
        check("rand_miss", 32'(bus.miss_count), exp_miss);
        check("imem_addr_stable", addr_unstable, 32'd0);

        // T6: strobe during WAIT, then enough hits to saturate
        do_flush();
        cur_lat = 4;
        bus.pc  = 5'd0;
        @(negedge clock);
        exp_miss = sat(exp_miss);
        check("t6_req", {31'd0, bus.imem_req}, 32'd1);
        bus.fetch_strobe = 1'b1;
        @(negedge clock);
        bus.fetch_strobe = 1'b0;
        check("t6_late", {31'd0, bus.fetch_late}, 32'd1);
        wait_ready(k);
        check("t6_instr", 32'(bus.instruction), 32'(mem[0]));
        cached[0] = 0;
        m_pc = 0;
        m_ready = 1'b1;
        goto_pc(5'd2, 1);
        for (int n = 0; n < 300; n++) begin
            goto_pc((n % 2 == 0) ? 5'd0 : 5'd2, 1);
        end
        check("t6_hit_sat", 32'(bus.hit_count), 32'd255);
        check("t6_late_sticky", {31'd0, bus.fetch_late}, 32'd1);

        // Asynchronous reset during WAIT drops the request without a clock edge
        do_flush();
        cur_lat = 4;
        bus.pc  = 5'd8;
        @(negedge clock);
        check("ar_req", {31'd0, bus.imem_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_req_drop", {31'd0, bus.imem_req}, 32'd0);
        check("ar_hits", 32'(bus.hit_count), 32'd0);
        check("ar_late", {31'd0, bus.fetch_late}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
